// File: rtl/unified_mem_arbiter.sv
// ---------------------------------------------------------------------------
// unified_mem_arbiter
//
// Shares a single byte-wide, asynchronous-read memory between the core's
// instruction-fetch port and its load/store data port. Each granted request
// becomes a 4-byte big-endian word transfer: byte k at (base + k) maps to
// word bits [31-8k : 24-8k]. Addresses wrap modulo 2^AW.
//
// Sequence per transaction: IDLE (grant) -> 4 x XFER (one byte each) -> DONE.
// Simultaneous requests alternate, starting with the data port after reset.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   if_req/if_addr       fetch request and byte base address (held to done)
//   if_rdata/if_done     fetched word (held) and one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata  data request, store flag, address, store word
//   d_rdata/d_done       loaded word (held) and one-cycle completion pulse
//   mem_addr/mem_we/mem_wdata  byte address, write enable, write byte
//   mem_rdata            combinational read byte for mem_addr
//   busy                 high whenever the arbiter is not idle
// ---------------------------------------------------------------------------
module unified_mem_arbiter #(
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [31:0]   if_rdata,
    output logic          if_done,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic [31:0]   d_rdata,
    output logic          d_done,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic          busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

    logic [1:0]    state_reg;
    logic [1:0]    cnt_reg;
    logic          owner_reg;
    logic          last_grant_reg;
    logic [AW-1:0] base_reg;
    logic          we_reg;
    logic [31:0]   wdata_reg;
    logic [31:0]   shadow_reg;
    logic [31:0]   shadow_next;
    logic [31:0]   if_rdata_reg;
    logic [31:0]   d_rdata_reg;

    logic          grant_valid;
    logic          grant_data;
    logic [1:0]    lane_sel;
    logic [7:0]    wdata_lane [4];

    // Data wins when it is the only requester, or on a tie when fetch was
    // served last.
    assign grant_valid = if_req | d_req;
    assign grant_data  = d_req & (~if_req | (last_grant_reg == OWN_FETCH));

    // Byte cnt sits in lane 3-cnt (big-endian: byte 0 is the MSB lane).
    assign lane_sel = 2'd3 - cnt_reg;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign wdata_lane[gi] = wdata_reg[8*gi +: 8];
        end
    endgenerate

    // Shadow word with the current read byte merged in; used both for the
    // per-byte capture and to publish the complete word on the final byte.
    always_comb begin
        shadow_next = shadow_reg;
        shadow_next[{lane_sel, 3'b000} +: 8] = mem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= 2'd0;
            owner_reg      <= OWN_FETCH;
            last_grant_reg <= OWN_FETCH;
            base_reg       <= '0;
            we_reg         <= 1'b0;
            wdata_reg      <= 32'd0;
            shadow_reg     <= 32'd0;
            if_rdata_reg   <= 32'd0;
            d_rdata_reg    <= 32'd0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (grant_valid) begin
                        owner_reg      <= grant_data;
                        last_grant_reg <= grant_data;
                        base_reg       <= grant_data ? d_addr : if_addr;
                        we_reg         <= grant_data & d_we;
                        wdata_reg      <= d_wdata;
                        cnt_reg        <= 2'd0;
                        state_reg      <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (!we_reg) begin
                        shadow_reg <= shadow_next;
                    end
                    cnt_reg <= cnt_reg + 2'd1;
                    if (cnt_reg == 2'd3) begin
                        state_reg <= S_DONE;
                        // Publish on the same edge that captures the last
                        // byte so rdata is valid for the whole DONE cycle.
                        if (!we_reg) begin
                            if (owner_reg == OWN_DATA) begin
                                d_rdata_reg <= shadow_next;
                            end else begin
                                if_rdata_reg <= shadow_next;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // Memory-side outputs are decoded from state so an asynchronous reset
    // drops mem_we immediately.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = 8'd0;
        if (state_reg == S_XFER) begin
            mem_addr = base_reg + AW'(cnt_reg);
            if (we_reg) begin
                mem_we    = 1'b1;
                mem_wdata = wdata_lane[lane_sel];
            end
        end
    end

    assign if_done  = (state_reg == S_DONE) && (owner_reg == OWN_FETCH);
    assign d_done   = (state_reg == S_DONE) && (owner_reg == OWN_DATA);
    assign busy     = (state_reg != S_IDLE);
    assign if_rdata = if_rdata_reg;
    assign d_rdata  = d_rdata_reg;

endmodule
